// File: rtl/hwpe_cfg_master_if.sv
// Periph-bus port between the HWPE config master and the engine's control slave.
// Request channel is master-driven; grant and read response come back from the slave.
interface hwpe_cfg_master_if #(
    parameter int unsigned ID_WIDTH = 10
) ();
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/hwpe_cfg_master.sv
// Periph-bus initiator: acquires an HWPE job context, writes the job registers,
// triggers the job and pulses done_o once the engine completion event arrives.
module hwpe_cfg_master #(
    parameter int unsigned N_JOB_REGS = 8,
    parameter int unsigned ID_WIDTH   = 10,
    parameter int unsigned MASTER_ID  = 0,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned BACKOFF    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [N_JOB_REGS-1:0][31:0] job_regs_i,
    input  logic                       evt_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [7:0]                 job_id_o,
    hwpe_cfg_master_if.master          periph
);

    localparam int unsigned KW = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
    localparam int unsigned CW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(N_JOB_REGS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BACKOFF - 1);
    localparam logic [31:0] TRIG_ADDR = BASE_ADDR;
    localparam logic [31:0] ACQ_ADDR  = BASE_ADDR + 32'h4;
    localparam logic [31:0] REG_ADDR  = BASE_ADDR + 32'h40;

    typedef enum logic [2:0] {
        S_IDLE, S_ACQ_REQ, S_ACQ_WAIT, S_BACKOFF, S_WR, S_TRIG, S_WAIT_EVT, S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [N_JOB_REGS-1:0][31:0] snap_q, snap_d;
    logic [7:0]                job_id_q, job_id_d;
    logic                      req_q, req_d;
    logic [31:0]               add_q, add_d;
    logic                      wen_q, wen_d;
    logic [3:0]                be_q, be_d;
    logic [31:0]               data_q, data_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      rsp_hit;
    logic                      unused_rdata;

    assign rsp_hit      = periph.r_valid && (periph.r_id == ID_WIDTH'(MASTER_ID));
    assign unused_rdata = ^periph.r_data[30:8];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            cnt_q    <= '0;
            snap_q   <= '0;
            job_id_q <= '0;
            req_q    <= 1'b0;
            add_q    <= '0;
            wen_q    <= 1'b1;
            be_q     <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            job_id_q <= job_id_d;
            req_q    <= req_d;
            add_q    <= add_d;
            wen_q    <= wen_d;
            be_q     <= be_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        job_id_d = job_id_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    snap_d  = job_regs_i;
                    k_d     = '0;
                    state_d = S_ACQ_REQ;
                end
            end
            S_ACQ_REQ: begin
                if (periph.gnt) state_d = S_ACQ_WAIT;
            end
            S_ACQ_WAIT: begin
                // bit31 set means every context is taken; retry after a pause
                if (rsp_hit) begin
                    if (periph.r_data[31]) begin
                        cnt_d   = '0;
                        state_d = S_BACKOFF;
                    end else begin
                        job_id_d = periph.r_data[7:0];
                        state_d  = S_WR;
                    end
                end
            end
            S_BACKOFF: begin
                if (cnt_q == CNT_LAST) state_d = S_ACQ_REQ;
                else                   cnt_d   = cnt_q + CW'(1);
            end
            S_WR: begin
                if (periph.gnt) begin
                    if (k_q == K_LAST) state_d = S_TRIG;
                    else               k_d     = k_q + KW'(1);
                end
            end
            S_TRIG: begin
                if (periph.gnt) state_d = S_WAIT_EVT;
            end
            S_WAIT_EVT: begin
                if (evt_i) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they hold steady until grant.
    always_comb begin
        req_d  = 1'b0;
        add_d  = '0;
        wen_d  = 1'b1;
        be_d   = '0;
        data_d = '0;

        case (state_d)
            S_ACQ_REQ: begin
                req_d = 1'b1;
                add_d = ACQ_ADDR;
                be_d  = 4'hF;
            end
            S_WR: begin
                req_d  = 1'b1;
                add_d  = REG_ADDR + (32'(k_d) << 2);
                wen_d  = 1'b0;
                be_d   = 4'hF;
                data_d = snap_d[k_d];
            end
            S_TRIG: begin
                req_d = 1'b1;
                add_d = TRIG_ADDR;
                wen_d = 1'b0;
                be_d  = 4'hF;
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign periph.req  = req_q;
    assign periph.add  = add_q;
    assign periph.wen  = wen_q;
    assign periph.be   = be_q;
    assign periph.data = data_q;
    assign periph.id   = ID_WIDTH'(MASTER_ID);
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign job_id_o    = job_id_q;

endmodule
